// File: rtl/scoreboard_pkg.sv
// Shared types and constants for the scoreboard: FSM state encoding, BCD and
// display digit widths, scan slot count and a packed-BCD increment helper.
package scoreboard_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StOver = 2'd2
   } state_e;

   localparam int unsigned BcdW     = 4;
   localparam int unsigned DigitW   = 5;
   localparam int unsigned NumSlots = 8;

   // Ripple +1 across four packed BCD digits; 9999 wraps to 0000.
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One decade of the score counter: counts 0..9 on inc, wraps to 0 and flags a
// carry into the next digit in the same cycle.
module bcd_digit_counter
   import scoreboard_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            clr,
   input  logic            inc,
   output logic [BcdW-1:0] q,
   output logic            carry
);

   assign carry = inc && (q == BcdW'(9));

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         q <= '0;
      end else if (inc) begin
         q <= (q == BcdW'(9)) ? '0 : q + BcdW'(1);
      end
   end

endmodule

// File: rtl/scoreboard_sequencer.sv
// Scoreboard core: game-phase FSM, 4-digit BCD score with saturation, high-score
// register, and the 8-slot seven-segment scan counter with active-low anodes.
module scoreboard_sequencer
   import scoreboard_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter logic [15:0] SCORE_MAX   = 16'h9999
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        game_start,
   input  logic                        score_inc,
   input  logic                        player_dead,
   output logic [DigitW-1:0]           digit0,
   output logic [DigitW-1:0]           digit1,
   output logic [DigitW-1:0]           digit2,
   output logic [DigitW-1:0]           digit3,
   output logic [15:0]                 hi_score,
   output logic [$clog2(NumSlots)-1:0] refreshcounter,
   output logic [NumSlots-1:0]         anode,
   output logic                        gameover
);

   localparam int unsigned PreW = $clog2(REFRESH_DIV);
   localparam logic [PreW-1:0] PreMax = PreW'(REFRESH_DIV - 1);

   state_e            state;
   logic [PreW-1:0]   prescaler;
   logic [BcdW-1:0]   q [4];
   logic [4:0]        chain;
   logic [15:0]       score;
   logic [15:0]       score_fin;

   assign score = {q[3], q[2], q[1], q[0]};

   // game_start owns the cycle: it clears the score and masks any increment.
   assign chain[0] = score_inc && (state == StRun) && !game_start && (score != SCORE_MAX);

   for (genvar i = 0; i < 4; i++) begin : g_digit
      bcd_digit_counter u_digit (
         .clk   (clk),
         .reset (reset),
         .clr   (game_start),
         .inc   (chain[i]),
         .q     (q[i]),
         .carry (chain[i+1])
      );
   end

   // Score as it will be after this edge, so a same-cycle increment counts.
   assign score_fin = chain[0] ? bcd_inc(score) : score;

   assign digit0 = {{(DigitW - BcdW){1'b0}}, q[0]};
   assign digit1 = {{(DigitW - BcdW){1'b0}}, q[1]};
   assign digit2 = {{(DigitW - BcdW){1'b0}}, q[2]};
   assign digit3 = {{(DigitW - BcdW){1'b0}}, q[3]};

   assign anode = ~(NumSlots'(1) << refreshcounter);

   always_ff @(posedge clk) begin
      if (reset) begin
         prescaler      <= '0;
         refreshcounter <= '0;
      end else if (prescaler == PreMax) begin
         prescaler      <= '0;
         refreshcounter <= refreshcounter + 1'b1;
      end else begin
         prescaler      <= prescaler + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= StIdle;
         gameover <= 1'b0;
         hi_score <= '0;
      end else begin
         case (state)
            StRun: begin
               if (game_start) begin
                  gameover <= 1'b0;
               end else if (player_dead) begin
                  state    <= StOver;
                  gameover <= 1'b1;
                  if (score_fin > hi_score) hi_score <= score_fin;
               end
            end
            StOver: begin
               if (game_start) begin
                  state    <= StRun;
                  gameover <= 1'b0;
               end
            end
            default: begin
               gameover <= 1'b0;
               state    <= game_start ? StRun : StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_scoreboard_sequencer.sv
// Directed bench for scoreboard_sequencer with a short scan divider; expected
// values are hand-computed constants.
module tb_scoreboard_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        game_start;
   logic        score_inc;
   logic        player_dead;
   logic [4:0]  digit0, digit1, digit2, digit3;
   logic [15:0] hi_score;
   logic [2:0]  refreshcounter;
   logic [7:0]  anode;
   logic        gameover;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   scoreboard_sequencer #(
      .REFRESH_DIV (4),
      .SCORE_MAX   (16'h9999)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .game_start     (game_start),
      .score_inc      (score_inc),
      .player_dead    (player_dead),
      .digit0         (digit0),
      .digit1         (digit1),
      .digit2         (digit2),
      .digit3         (digit3),
      .hi_score       (hi_score),
      .refreshcounter (refreshcounter),
      .anode          (anode),
      .gameover       (gameover)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] score_now();
      return {digit3[3:0], digit2[3:0], digit1[3:0], digit0[3:0]};
   endfunction

   // Drive one cycle of pulses starting just after a negedge; returns at the next negedge.
   task automatic pulse(input logic gs, input logic inc, input logic pd);
      game_start  = gs;
      score_inc   = inc;
      player_dead = pd;
      @(negedge clk);
      game_start  = 1'b0;
      score_inc   = 1'b0;
      player_dead = 1'b0;
   endtask

   task automatic incs(input int n);
      score_inc = 1'b1;
      repeat (n) @(negedge clk);
      score_inc = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      game_start  = 1'b0;
      score_inc   = 1'b0;
      player_dead = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // 1: reset state and idle scan
      chk("rst_slot", 32'(refreshcounter), 32'd0);
      chk("rst_anode", 32'(anode), 32'hFE);
      chk("rst_over", 32'(gameover), 32'd0);
      chk("rst_hi", 32'(hi_score), 32'h0);
      chk("rst_score", 32'(score_now()), 32'h0);
      for (int k = 1; k <= 40; k++) begin
         logic [2:0] es;
         logic [7:0] ea;
         @(negedge clk);
         es = 3'((k / 4) % 8);
         ea = ~(8'd1 << es);
         chk("scan_slot", 32'(refreshcounter), 32'(es));
         chk("scan_anode", 32'(anode), 32'(ea));
         chk("scan_over", 32'(gameover), 32'd0);
      end

      // 2: 1000 increments ripple to 0x1000
      pulse(1'b1, 1'b0, 1'b0);
      incs(1000);
      chk("d0", 32'(digit0), 32'd0);
      chk("d1", 32'(digit1), 32'd0);
      chk("d2", 32'(digit2), 32'd0);
      chk("d3", 32'(digit3), 32'd1);
      chk("s1000_over", 32'(gameover), 32'd0);

      // 3: saturation at 0x9999
      incs(8998);
      chk("s9998", 32'(score_now()), 32'h9998);
      incs(1);
      chk("s9999", 32'(score_now()), 32'h9999);
      incs(2);
      chk("sat", 32'(score_now()), 32'h9999);
      chk("sat_d3_bit4", 32'(digit3), 32'd9);

      // 4: same-cycle inc+dead, then lower score keeps hi_score
      pulse(1'b1, 1'b0, 1'b0);
      chk("restart_zero", 32'(score_now()), 32'h0);
      incs(42);
      chk("s42", 32'(score_now()), 32'h0042);
      pulse(1'b0, 1'b1, 1'b1);
      chk("incdead_score", 32'(score_now()), 32'h0043);
      chk("incdead_over", 32'(gameover), 32'd1);
      chk("incdead_hi", 32'(hi_score), 32'h0043);
      pulse(1'b1, 1'b0, 1'b0);
      chk("new_over", 32'(gameover), 32'd0);
      incs(10);
      pulse(1'b0, 1'b0, 1'b1);
      chk("low_score", 32'(score_now()), 32'h0010);
      chk("low_over", 32'(gameover), 32'd1);
      chk("low_hi", 32'(hi_score), 32'h0043);

      // 5: pulses ignored in OVER; game_start wins in RUN
      pulse(1'b0, 1'b1, 1'b0);
      chk("over_inc", 32'(score_now()), 32'h0010);
      pulse(1'b0, 1'b0, 1'b1);
      chk("over_dead_score", 32'(score_now()), 32'h0010);
      chk("over_dead_over", 32'(gameover), 32'd1);
      chk("over_dead_hi", 32'(hi_score), 32'h0043);
      pulse(1'b1, 1'b0, 1'b0);
      incs(5);
      pulse(1'b1, 1'b0, 1'b1);
      chk("gs_dead_score", 32'(score_now()), 32'h0);
      chk("gs_dead_over", 32'(gameover), 32'd0);
      incs(3);
      pulse(1'b1, 1'b1, 1'b0);
      chk("gs_inc_score", 32'(score_now()), 32'h0);
      incs(1);
      chk("still_run", 32'(score_now()), 32'h0001);

      // 6: reset mid-game
      pulse(1'b1, 1'b0, 1'b0);
      incs(123);
      chk("s123", 32'(score_now()), 32'h0123);
      incs(1000);
      pulse(1'b0, 1'b0, 1'b1);
      chk("hi_1123", 32'(hi_score), 32'h1123);
      pulse(1'b1, 1'b0, 1'b0);
      incs(123);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid_rst_score", 32'(score_now()), 32'h0);
      chk("mid_rst_hi", 32'(hi_score), 32'h0);
      chk("mid_rst_over", 32'(gameover), 32'd0);
      chk("mid_rst_slot", 32'(refreshcounter), 32'd0);
      chk("mid_rst_anode", 32'(anode), 32'hFE);
      pulse(1'b0, 1'b1, 1'b0);
      chk("idle_inc", 32'(score_now()), 32'h0);
      pulse(1'b0, 1'b0, 1'b1);
      chk("idle_dead", 32'(gameover), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
